// File: rtl/ep_scan_if.sv
// Signal bundle between the indicator scan controller and its host/EP converter.
// The host side (master) supplies load data and the converter result; the controller (slave) drives the display.
interface ep_scan_if #(
  parameter int NDIG = 4
);
  logic [4*NDIG-1:0] D;
  logic              LD;
  logic              ACK;
  logic              LZB;
  logic [3:0]        X;
  logic [3:0]        Y;
  logic [3:0]        SEG;
  logic [NDIG-1:0]   AN;
  logic              FRM;

  modport master (
    output D, LD, LZB, Y,
    input  ACK, X, SEG, AN, FRM
  );

  modport slave (
    input  D, LD, LZB, Y,
    output ACK, X, SEG, AN, FRM
  );
endinterface

// File: rtl/ep_scan_ctrl.sv
// Time-multiplexed scan controller: one shared EP code converter serves NDIG digits,
// with a blank phase per slot, leading-zero blanking and frame-synchronous double-buffered loads.
module ep_scan_ctrl #(
  parameter int NDIG      = 4,
  parameter int DWELL     = 16,
  parameter int BLANK_CYC = 2
) (
  input  logic       TG,
  input  logic       nRST,
  ep_scan_if.slave   bus
);

  localparam int CW = $clog2(DWELL);
  localparam int IW = $clog2(NDIG);
  localparam int DW = 4 * NDIG;

  localparam logic [CW-1:0]   CNT_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0]   CNT_SHOW = CW'(BLANK_CYC - 1);
  localparam logic [IW-1:0]   IDX_LAST = IW'(NDIG - 1);
  localparam logic [NDIG-1:0] AN_OFF   = '1;

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [DW-1:0]   disp_q, disp_d;
  logic [DW-1:0]   pend_q, pend_d;
  logic            pend_vld_q, pend_vld_d;
  logic [3:0]      x_q, x_d;
  logic [3:0]      seg_q, seg_d;
  logic [NDIG-1:0] an_q, an_d;
  logic            ack_q, ack_d;
  logic            frm_q, frm_d;

  logic slot_end;
  logic wrap;
  logic lz_blank;

  assign slot_end = (cnt_q == CNT_LAST);
  assign wrap     = slot_end && (idx_q == IDX_LAST);

  // A digit is blanked when it and every more significant digit are zero.
  always_comb begin
    lz_blank = bus.LZB && (idx_q != '0);
    for (int i = 0; i < NDIG; i++) begin
      if ((i >= int'(idx_q)) && (disp_q[4*i +: 4] != 4'h0)) lz_blank = 1'b0;
    end
  end

  // NOTE: every signal gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d      = cnt_q + 1'b1;
    idx_d      = idx_q;
    disp_d     = disp_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    x_d        = x_q;
    seg_d      = seg_q;
    an_d       = an_q;
    ack_d      = 1'b0;
    frm_d      = 1'b0;

    if (bus.LD) begin
      pend_d     = bus.D;
      pend_vld_d = 1'b1;
    end

    // Frame boundary: a load on this very edge wins over the older pending value.
    if (wrap) begin
      frm_d      = 1'b1;
      pend_vld_d = 1'b0;
      if (bus.LD) begin
        disp_d = bus.D;
        ack_d  = 1'b1;
      end else if (pend_vld_q) begin
        disp_d = pend_q;
        ack_d  = 1'b1;
      end
    end

    // X is taken from the post-commit buffer so digit 0 of a new frame already shows new data.
    if (slot_end) begin
      cnt_d = '0;
      idx_d = wrap ? '0 : idx_q + 1'b1;
      an_d  = AN_OFF;
      x_d   = disp_d[4*idx_d +: 4];
    end

    if (cnt_q == CNT_SHOW) begin
      seg_d = bus.Y;
      if (!lz_blank) an_d = ~(NDIG'(1) << idx_q);
    end
  end

  // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values together.
  // NOTE: the display and pending buffers are reset too, so a fresh start shows zeros and discards stale loads.
  always_ff @(posedge TG or negedge nRST) begin
    if (!nRST) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      disp_q     <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      x_q        <= 4'h0;
      seg_q      <= 4'h0;
      an_q       <= AN_OFF;
      ack_q      <= 1'b0;
      frm_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      disp_q     <= disp_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      x_q        <= x_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      ack_q      <= ack_d;
      frm_q      <= frm_d;
    end
  end

  assign bus.X   = x_q;
  assign bus.SEG = seg_q;
  assign bus.AN  = an_q;
  assign bus.ACK = ack_q;
  assign bus.FRM = frm_q;

endmodule

// File: tb/tb_ep_scan_ctrl.sv
// Directed self-checking bench for ep_scan_ctrl (NDIG=4, DWELL=8, BLANK_CYC=2)
// with a behavioural EP converter driving Y from X.
module tb_ep_scan_ctrl;

  localparam int NDIG  = 4;
  localparam int DWELL = 8;
  localparam int BLANK = 2;
  localparam int FRAME = NDIG * DWELL;

  logic TG;
  logic nRST;
  int   checks = 0;
  int   errors = 0;

  ep_scan_if #(.NDIG(NDIG)) bus ();

  ep_scan_ctrl #(
    .NDIG      (NDIG),
    .DWELL     (DWELL),
    .BLANK_CYC (BLANK)
  ) dut (
    .TG   (TG),
    .nRST (nRST),
    .bus  (bus)
  );

  // Stand-in EP converter: a fixed bijective 4-bit mapping.
  function automatic logic [3:0] ep_conv(input logic [3:0] x);
    return {x[2:0], x[3]} ^ 4'h6;
  endfunction

  assign bus.Y = ep_conv(bus.X);

  initial begin
    TG = 1'b0;
    forever #5 TG = ~TG;
  end

  task automatic tick();
    @(posedge TG);
    #1;
  endtask

  // Scans one full frame starting at its first cycle, checking every cycle, with up to two loads injected.
  task automatic run_frame(input logic [15:0] disp, input logic lzb, input logic [3:0] lit,
                           input int ld_a, input logic [15:0] da,
                           input int ld_b, input logic [15:0] db);
    bus.LZB = lzb;
    for (int k = 0; k < FRAME; k++) begin
      int         s;
      int         c;
      logic [3:0] nib;
      logic [3:0] exp_an;
      s      = k / DWELL;
      c      = k % DWELL;
      nib    = disp[4*s +: 4];
      exp_an = 4'b1111;
      if (c >= BLANK && lit[s]) exp_an[s] = 1'b0;

      checks++;
      if (bus.X !== nib) begin
        errors++;
        $display("FAIL x d%0d c%0d: got %h expected %h", s, c, bus.X, nib);
      end
      checks++;
      if (bus.AN !== exp_an) begin
        errors++;
        $display("FAIL an d%0d c%0d: got %b expected %b", s, c, bus.AN, exp_an);
      end
      if (c >= BLANK) begin
        checks++;
        if (bus.SEG !== ep_conv(nib)) begin
          errors++;
          $display("FAIL seg d%0d c%0d: got %h expected %h", s, c, bus.SEG, ep_conv(nib));
        end
      end
      if (k > 0) begin
        checks++;
        if (bus.ACK !== 1'b0 || bus.FRM !== 1'b0) begin
          errors++;
          $display("FAIL midframe_pulse k%0d: got ack=%b frm=%b expected ack=0 frm=0", k, bus.ACK, bus.FRM);
        end
      end

      if (k == ld_a) begin
        bus.LD = 1'b1;
        bus.D  = da;
      end else if (k == ld_b) begin
        bus.LD = 1'b1;
        bus.D  = db;
      end
      tick();
      bus.LD = 1'b0;
    end
  endtask

  task automatic test_reset();
    nRST    = 1'b0;
    bus.LD  = 1'b0;
    bus.D   = '0;
    bus.LZB = 1'b0;
    repeat (3) @(posedge TG);
    #1;
    checks++;
    if (bus.AN !== 4'b1111 || bus.SEG !== 4'h0 || bus.X !== 4'h0) begin
      errors++;
      $display("FAIL reset_outputs: got an=%b seg=%h x=%h expected an=1111 seg=0 x=0", bus.AN, bus.SEG, bus.X);
    end
    checks++;
    if (bus.ACK !== 1'b0 || bus.FRM !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulses: got ack=%b frm=%b expected ack=0 frm=0", bus.ACK, bus.FRM);
    end
    nRST = 1'b1;
    run_frame(16'h0000, 1'b0, 4'b1111, -1, 16'h0, -1, 16'h0);
    checks++;
    if (bus.ACK !== 1'b0 || bus.FRM !== 1'b1) begin
      errors++;
      $display("FAIL first_wrap: got ack=%b frm=%b expected ack=0 frm=1", bus.ACK, bus.FRM);
    end
  endtask

  task automatic test_load();
    run_frame(16'h0000, 1'b0, 4'b1111, 10, 16'h1234, -1, 16'h0);
    checks++;
    if (bus.ACK !== 1'b1 || bus.FRM !== 1'b1) begin
      errors++;
      $display("FAIL load_ack: got ack=%b frm=%b expected ack=1 frm=1", bus.ACK, bus.FRM);
    end
    run_frame(16'h1234, 1'b0, 4'b1111, -1, 16'h0, -1, 16'h0);
    checks++;
    if (bus.ACK !== 1'b0 || bus.FRM !== 1'b1) begin
      errors++;
      $display("FAIL load_no_reack: got ack=%b frm=%b expected ack=0 frm=1", bus.ACK, bus.FRM);
    end
  endtask

  task automatic test_overwrite();
    run_frame(16'h1234, 1'b0, 4'b1111, 5, 16'h1111, 20, 16'h2222);
    checks++;
    if (bus.ACK !== 1'b1 || bus.FRM !== 1'b1) begin
      errors++;
      $display("FAIL overwrite_ack: got ack=%b frm=%b expected ack=1 frm=1", bus.ACK, bus.FRM);
    end
    run_frame(16'h2222, 1'b0, 4'b1111, -1, 16'h0, -1, 16'h0);
    checks++;
    if (bus.ACK !== 1'b0) begin
      errors++;
      $display("FAIL overwrite_single_ack: got ack=%b expected 0", bus.ACK);
    end
  endtask

  task automatic test_blanking();
    run_frame(16'h2222, 1'b0, 4'b1111, 3, 16'h0050, -1, 16'h0);
    checks++;
    if (bus.ACK !== 1'b1) begin
      errors++;
      $display("FAIL blank_load_ack: got ack=%b expected 1", bus.ACK);
    end
    run_frame(16'h0050, 1'b1, 4'b0011, 7, 16'h0000, -1, 16'h0);
    checks++;
    if (bus.ACK !== 1'b1) begin
      errors++;
      $display("FAIL blank_zero_ack: got ack=%b expected 1", bus.ACK);
    end
    run_frame(16'h0000, 1'b1, 4'b0001, -1, 16'h0, -1, 16'h0);
    checks++;
    if (bus.ACK !== 1'b0 || bus.FRM !== 1'b1) begin
      errors++;
      $display("FAIL blank_end: got ack=%b frm=%b expected ack=0 frm=1", bus.ACK, bus.FRM);
    end
  endtask

  task automatic test_back_to_back();
    run_frame(16'h0000, 1'b0, 4'b1111, FRAME - 1, 16'hABCD, -1, 16'h0);
    checks++;
    if (bus.ACK !== 1'b1 || bus.FRM !== 1'b1) begin
      errors++;
      $display("FAIL coincident_ack: got ack=%b frm=%b expected ack=1 frm=1", bus.ACK, bus.FRM);
    end
    run_frame(16'hABCD, 1'b0, 4'b1111, -1, 16'h0, -1, 16'h0);
    checks++;
    if (bus.ACK !== 1'b0) begin
      errors++;
      $display("FAIL coincident_single_ack: got ack=%b expected 0", bus.ACK);
    end
  endtask

  task automatic test_reset_mid_frame();
    bus.LZB = 1'b0;
    for (int k = 0; k < 2 * DWELL + 4; k++) begin
      if (k == 1) begin
        bus.LD = 1'b1;
        bus.D  = 16'h5555;
      end
      tick();
      bus.LD = 1'b0;
    end
    checks++;
    if (bus.AN !== 4'b1011 || bus.X !== 4'hB) begin
      errors++;
      $display("FAIL premid_digit2: got an=%b x=%h expected an=1011 x=b", bus.AN, bus.X);
    end
    #2 nRST = 1'b0;
    #1;
    checks++;
    if (bus.AN !== 4'b1111 || bus.SEG !== 4'h0 || bus.X !== 4'h0) begin
      errors++;
      $display("FAIL async_reset: got an=%b seg=%h x=%h expected an=1111 seg=0 x=0", bus.AN, bus.SEG, bus.X);
    end
    @(posedge TG);
    #1;
    nRST = 1'b1;
    run_frame(16'h0000, 1'b0, 4'b1111, -1, 16'h0, -1, 16'h0);
    checks++;
    if (bus.ACK !== 1'b0 || bus.FRM !== 1'b1) begin
      errors++;
      $display("FAIL lost_pending: got ack=%b frm=%b expected ack=0 frm=1", bus.ACK, bus.FRM);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_overwrite();
    test_blanking();
    test_back_to_back();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ep_scan_ctrl.md
Name: ep_scan_ctrl

Overview:
- Time-multiplexed scan controller for a multi-digit indicator.
- Shares one EP code converter (4-bit code in X, 4-bit indicator code out Y) among NDIG digits.
- Each digit slot: presents the digit nibble to the converter, registers the converted code, then enables that digit's common line.
- Double-buffered value load with LD/ACK handshake; new values commit only at frame boundaries, so no tearing.

Parameters:
- NDIG, 4, number of indicator digits (≥2); digit 0 is least significant.
- DWELL, 16, clocks per digit slot; must be > BLANK_CYC.
- BLANK_CYC, 2, clocks at the start of each slot with all digits off (anti-ghosting); must be ≥1.

Ports:
- TG, input, 1: system clock; all state updates on rising edge.
- nRST, input, 1: asynchronous active-low reset.
- D, input, 4*NDIG: value to display; nibble i goes to digit i.
- LD, input, 1: load strobe; D is sampled on every TG edge where LD=1.
- ACK, output, 1: one-cycle pulse when a loaded value is committed to the display buffer.
- LZB, input, 1: leading-zero blanking enable.
- X, output, 4: code to the shared EP converter.
- Y, input, 4: converted code from EP; combinational from X.
- SEG, output, 4: registered indicator code to the display.
- AN, output, NDIG: digit enables, active-low; at most one bit is low.
- FRM, output, 1: one-cycle pulse in the first cycle of each frame.

Behaviour:
- Reset (nRST=0, immediate, independent of TG):
  - cnt=0, idx=0.
  - AN all ones, SEG=0, X=0, ACK=0, FRM=0.
  - Display buffer = 0, pending buffer = 0, pending flag = 0.
  - After release, scanning starts at digit 0, cnt=0.
  - FRM is not pulsed for the first frame after reset.
- Slot counter cnt:
  - Counts 0..DWELL-1.
  - At DWELL-1: cnt←0 and idx advances by 1; after NDIG-1 it wraps to 0.
  - Frame length = NDIG*DWELL clocks.
- X:
  - Registered.
  - Updated on the edge where cnt becomes 0; holds display-buffer nibble[idx] for the whole slot.
- Blank phase, cnt < BLANK_CYC:
  - AN all ones.
  - On the edge ending cnt=BLANK_CYC-1, SEG←Y and AN←one-hot-low(idx), unless the digit is blanked.
  - Digit is visible for DWELL-BLANK_CYC cycles.
- Slot end: on the edge ending cnt=DWELL-1, AN←all ones. SEG holds its value.
- Leading-zero blanking:
  - Applies when LZB=1, idx≠0, and nibbles idx..NDIG-1 of the display buffer are all zero.
  - In that case AN stays all ones for the whole slot; SEG is still updated.
  - Digit 0 is never blanked.
- Load handshake:
  - LD=1 copies D into the pending buffer and sets the pending flag.
  - Later LDs in the same frame overwrite the pending value; latest wins.
- Commit (on the wrap edge, idx NDIG-1→0):
  - If the pending flag is set, display buffer←pending, flag cleared, ACK=1 for the next cycle.
  - If LD=1 on that same edge, D bypasses the pending buffer, is committed directly, and ACK is pulsed.
  - FRM=1 in the same cycle as any ACK.
  - ACK is never asserted twice for one commit.
- Reset mid-operation: pending data is discarded and no ACK is issued.
- X, SEG and AN are all registered; there is no combinational path from D or Y to any output.

Test Plan (NDIG=4, DWELL=8, BLANK_CYC=2):
- Reset: hold nRST=0 → AN=4'b1111, SEG=0, ACK=0. Release → AN=1110 first goes low at cycle 2 after release and stays low for 6 cycles.
- Load: LD pulse with D=16'h1234 mid-frame → display unchanged until wrap. Then one ACK pulse coincident with FRM. Next frame: X=4,3,2,1; AN=1110,1101,1011,0111, each active 6 of 8 cycles; SEG equals the EP output for each code.
- Overwrite: LD 16'h1111 then 16'h2222 in the same frame → exactly one ACK; next frame shows 2222.
- Blanking: LZB=1, D=16'h0050 → AN never 1011 or 0111; digits 0 and 1 lit. D=0 → only AN=1110 ever asserted.
- Reset mid-frame: nRST low during digit 2 visible → AN=1111 without a clock edge. A pending load is lost (no ACK); scanning restarts at digit 0.
- Coincident load: LD on the wrap edge with D=16'hABCD → ACK and FRM next cycle; digit 0 in that frame shows D.
